// File: rtl/pwm_capture.sv
// PWM input capture: measures the period and high time of pwm_in in prescaled ticks.
// Optional glitch filter on the synchronized input is enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  input  logic        en,
  input  logic        clear,
  input  logic [7:0]  prescale,
  output logic [15:0] period_val,
  output logic [15:0] high_val,
  output logic        cap_valid,
  output logic        overflow,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   lvl;
  logic                   edge_q;
  logic                   rise;
  logic                   fall;

  logic [3:0]  p_q, p_d;
  logic [15:0] limit;
  logic [15:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] high_tmp_q, high_tmp_d;
  logic [15:0] period_d, high_d;
  logic        cap_d, ovf_d;
  logic        tick;
  logic [15:0] meas;
  logic [15:0] presc_run;
  logic [15:0] cnt_run;
  logic        cnt_full;

  logic unused_prescale_hi;
  assign unused_prescale_hi = ^prescale[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      edge_q <= lvl;
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  // Level follows the synchronizer only once three consecutive samples agree.
  logic [1:0] hist_q;
  logic       filt_q;

  assign lvl = (sync_lvl == hist_q[0] && sync_lvl == hist_q[1]) ? sync_lvl : filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_lvl};
      filt_q <= lvl;
    end
  end
`else
  assign lvl = sync_lvl;
`endif

  assign rise = lvl & ~edge_q;
  assign fall = ~lvl & edge_q;

  // presc_q counts cycles since the last tick; tick lands on cycles k>0 with k mod 2^p == 0.
  assign limit     = 16'((17'd1 << p_q) - 17'd1);
  assign tick      = (presc_q == limit);
  assign cnt_full  = (cnt_q == 16'hFFFF);
  assign meas      = cnt_q + {15'd0, tick};
  assign presc_run = tick ? 16'd0 : presc_q + 16'd1;
  assign cnt_run   = (tick && !cnt_full) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    high_tmp_d = high_tmp_q;
    period_d   = period_val;
    high_d     = high_val;
    cap_d      = 1'b0;
    ovf_d      = overflow;

    if (clear) begin
      state_d    = IDLE;
      presc_d    = '0;
      cnt_d      = '0;
      high_tmp_d = '0;
      period_d   = '0;
      high_d     = '0;
      ovf_d      = 1'b0;
    end else if (!en) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HIGH;
            presc_d = '0;
            cnt_d   = '0;
            p_d     = prescale[3:0];
          end
        end
        HIGH: begin
          if (tick && cnt_full) begin
            state_d = IDLE;
            ovf_d   = 1'b1;
          end else begin
            presc_d = presc_run;
            cnt_d   = cnt_run;
            if (fall) begin
              high_tmp_d = meas;
              state_d    = LOW;
            end
          end
        end
        LOW: begin
          if (tick && cnt_full) begin
            state_d = IDLE;
            ovf_d   = 1'b1;
          end else if (rise) begin
            // Closing edge of this period is also the opening edge of the next.
            period_d = meas;
            high_d   = high_tmp_q;
            cap_d    = 1'b1;
            state_d  = HIGH;
            presc_d  = '0;
            cnt_d    = '0;
            p_d      = prescale[3:0];
          end else begin
            presc_d = presc_run;
            cnt_d   = cnt_run;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q        <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_val <= '0;
      high_val   <= '0;
      cap_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      p_q        <= p_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      high_tmp_q <= high_tmp_d;
      period_val <= period_d;
      high_val   <= high_d;
      cap_valid  <= cap_d;
      overflow   <= ovf_d;
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: captures are scoreboarded against hand-computed
// {period, high} pairs; state, hold and clear behaviour checked at phase boundaries.
module tb_pwm_capture;

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic        en;
  logic        clear;
  logic [7:0]  prescale;
  logic [15:0] period_val;
  logic [15:0] high_val;
  logic        cap_valid;
  logic        overflow;
  logic [1:0]  fsm_state;

  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int EV_LAT = 4;
`else
  localparam int EV_LAT = 2;
`endif

  int checks   = 0;
  int failures = 0;
  int cap_count  = 0;
  int stray_caps = 0;
  int cyc = 0;
  int last_cap_cyc = -1;
  int spacing_exp = 0;
  int caps_before;

  logic [31:0] exp_q[$];

  pwm_capture #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .en         (en),
    .clear      (clear),
    .prescale   (prescale),
    .period_val (period_val),
    .high_val   (high_val),
    .cap_valid  (cap_valid),
    .overflow   (overflow),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pwm(input int hi, input int lo);
    pwm_in = 1'b1;
    step(hi);
    pwm_in = 1'b0;
    step(lo);
  endtask

  task automatic glitch_period();
    pwm_in = 1'b1; step(10);
    pwm_in = 1'b0; step(2);
    pwm_in = 1'b1; step(28);
    pwm_in = 1'b0; step(60);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic expect_cap(input logic [15:0] per, input logic [15:0] hi);
    exp_q.push_back({per, hi});
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (cap_valid) begin
      cap_count++;
      if (spacing_exp != 0 && last_cap_cyc >= 0)
        check("cap_spacing", 32'(cyc - last_cap_cyc), 32'(spacing_exp));
      last_cap_cyc = cyc;
      if (exp_q.size() == 0) begin
        stray_caps++;
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("cap_period", {16'd0, period_val}, {16'd0, e[31:16]});
        check("cap_high",   {16'd0, high_val},   {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    rst = 1'b1; pwm_in = 1'b0; en = 1'b0; clear = 1'b0; prescale = 8'd0;
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_period",   {16'd0, period_val}, 32'd0);
    check("rst_high",     {16'd0, high_val},   32'd0);
    check("rst_cap",      {31'd0, cap_valid},  32'd0);
    check("rst_overflow", {31'd0, overflow},   32'd0);
    check("rst_state",    {30'd0, fsm_state},  {30'd0, ST_IDLE});

    // p=0, 4 periods of 100/25: three captures spaced 100 cycles apart
    en = 1'b1; prescale = 8'd0; step(5);
    caps_before = cap_count;
    spacing_exp = 100; last_cap_cyc = -1;
    repeat (3) expect_cap(16'd100, 16'd25);
    repeat (4) drive_pwm(25, 75);
    step(20);
    check("p0_cap_count", 32'(cap_count - caps_before), 32'd3);
    check("p0_queue_empty", 32'(exp_q.size()), 32'd0);
    spacing_exp = 0;
    pulse_clear();
    check("clear_period", {16'd0, period_val}, 32'd0);
    check("clear_high",   {16'd0, high_val},   32'd0);

    // p=3 (upper prescale bits ignored): 800/200 twice, then 805/200 floors to 100
    prescale = 8'hF3; step(5);
    caps_before = cap_count;
    repeat (3) expect_cap(16'd100, 16'd25);
    drive_pwm(200, 600);
    drive_pwm(200, 600);
    drive_pwm(200, 605);
    drive_pwm(200, 600);
    check("p3_cap_count", 32'(cap_count - caps_before), 32'd3);
    pulse_clear();

    // en low after a valid capture holds results; re-enable needs two rising edges
    prescale = 8'd0; step(5);
    caps_before = cap_count;
    repeat (2) expect_cap(16'd100, 16'd30);
    repeat (3) drive_pwm(30, 70);
    check("en_pre_caps", 32'(cap_count - caps_before), 32'd2);
    en = 1'b0;
    drive_pwm(10, 90);
    check("en_off_period", {16'd0, period_val}, 32'd100);
    check("en_off_high",   {16'd0, high_val},   32'd30);
    check("en_off_state",  {30'd0, fsm_state},  {30'd0, ST_IDLE});
    en = 1'b1; step(2);
    caps_before = cap_count;
    drive_pwm(20, 60);
    check("en_first_edge_nocap", 32'(cap_count - caps_before), 32'd0);
    expect_cap(16'd80, 16'd20);
    drive_pwm(20, 60);
    check("en_second_edge_cap", 32'(cap_count - caps_before), 32'd1);

    // clear on the same cycle as a rising event
    pwm_in = 1'b1;
    step(EV_LAT);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_rise_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    step(28);
    pwm_in = 1'b0; step(70);
    caps_before = cap_count;
    drive_pwm(30, 70);
    check("clr_next_edge_nocap", 32'(cap_count - caps_before), 32'd0);
    expect_cap(16'd100, 16'd30);
    drive_pwm(30, 70);
    check("clr_then_cap", 32'(cap_count - caps_before), 32'd1);
    pulse_clear();

    // 2-cycle low glitches inside a 40-cycle high phase
    step(5);
    caps_before = cap_count;
`ifdef PWM_CAPTURE_FILTER_EN
    repeat (2) expect_cap(16'd100, 16'd40);
`else
    repeat (2) begin
      expect_cap(16'd12, 16'd10);
      expect_cap(16'd88, 16'd28);
    end
`endif
    glitch_period();
    glitch_period();
    pwm_in = 1'b1; step(5);
    pwm_in = 1'b0; step(50);
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_cap_count", 32'(cap_count - caps_before), 32'd2);
`else
    check("glitch_cap_count", 32'(cap_count - caps_before), 32'd4);
`endif

    // stuck high: overflow, back to IDLE, results held, no capture
    en = 1'b0; step(2);
    en = 1'b1; step(2);
    caps_before = cap_count;
    pwm_in = 1'b1;
    step(70000);
    check("ovf_flag",  {31'd0, overflow},  32'd1);
    check("ovf_state", {30'd0, fsm_state}, {30'd0, ST_IDLE});
    check("ovf_nocap", 32'(cap_count - caps_before), 32'd0);
`ifdef PWM_CAPTURE_FILTER_EN
    check("ovf_hold_period", {16'd0, period_val}, 32'd100);
`else
    check("ovf_hold_period", {16'd0, period_val}, 32'd88);
`endif
    pulse_clear();
    check("ovf_clear_flag",   {31'd0, overflow},   32'd0);
    check("ovf_clear_period", {16'd0, period_val}, 32'd0);
    check("ovf_clear_high",   {16'd0, high_val},   32'd0);
    pwm_in = 1'b0;
    step(10);

    check("stray_caps", 32'(stray_caps), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
